// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle MIPS-subset control unit.
// A single state register sequences fetch/decode/execute; the datapath
// strobes are decoded combinationally from the current state (FETCH and
// BRANCH also look at mem_ready / br_taken).
// Memory states (FETCH, MREAD, MWRITE) share one wait counter and fall into
// TRAP with a timeout fault if mem_ready never arrives.
// Optional feature: define MC_CONTROL_JAL_EN to decode jal into the LINK state.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic [3:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             rf_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       rf_wsel,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MADDR  = 4'd3;
  localparam logic [3:0] S_MREAD  = 4'd4;
  localparam logic [3:0] S_MWB    = 4'd5;
  localparam logic [3:0] S_MWRITE = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;
  localparam logic [3:0] S_LINK   = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CONTROL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_ILL  = 2'b01;
  localparam logic [1:0] FAULT_TMO  = 2'b10;

  // Counter value seen in the last permitted wait cycle; a miss there times out.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [1:0]       fault_q, fault_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic       tmo_hit_s;
  logic [7:0] wait_inc_s;
  logic       unused_instr_s;

  assign op_s           = instr[31:26];
  assign funct_s        = instr[5:0];
  assign unused_instr_s = ^instr[25:6];
  assign tmo_hit_s      = (wait_q == TMO_LAST);
  assign wait_inc_s     = wait_q + 8'd1;

  // Instruction decode: which state follows DECODE for a given opcode/funct.
  function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] funct);
    logic [3:0] nxt;
    nxt = S_TRAP;
    case (op)
      OP_LW, OP_SW: nxt = S_MADDR;
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: nxt = S_EXEC;
          default:                          nxt = S_TRAP;
        endcase
      end
      OP_BGTZ, OP_BEQ: nxt = S_BRANCH;
      OP_ADDI, OP_ORI: nxt = S_IEXEC;
      OP_J:            nxt = S_JUMP;
`ifdef MC_CONTROL_JAL_EN
      OP_JAL:          nxt = S_LINK;
`endif
      default:         nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  // Next-state, fault capture and memory wait counter.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = 8'd0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit_s) begin
          state_d = S_TRAP;
          fault_d = FAULT_TMO;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_DECODE: begin
        state_d = decode_next(op_s, funct_s);
        if (state_d == S_TRAP) begin
          fault_d = FAULT_ILL;
        end else begin
          fault_d = fault_q;
        end
      end
      S_MADDR: begin
        if (op_s == OP_LW) begin
          state_d = S_MREAD;
        end else begin
          state_d = S_MWRITE;
        end
      end
      S_MREAD: begin
        if (mem_ready) begin
          state_d = S_MWB;
        end else if (tmo_hit_s) begin
          state_d = S_TRAP;
          fault_d = FAULT_TMO;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_MWB: state_d = S_FETCH;
      S_MWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_hit_s) begin
          state_d = S_TRAP;
          fault_d = FAULT_TMO;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      S_LINK: begin
`ifdef MC_CONTROL_JAL_EN
        state_d = S_FETCH;
`else
        state_d = S_TRAP;
        fault_d = FAULT_ILL;
`endif
      end
      default: begin
        state_d = S_TRAP;
        fault_d = FAULT_ILL;
      end
    endcase
  end

  // Retired count: every return to FETCH except the start-up IDLE->FETCH.
  always_comb begin
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    pc_src  = 2'd0;
    alu_op  = 2'd0;
    rf_wsel = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end else begin
          ir_we = 1'b0;
          pc_we = 1'b0;
        end
      end
      S_MADDR:  alu_op = 2'd0;
      S_MREAD:  mem_re = 1'b1;
      S_MWB:    rf_we  = 1'b1;
      S_MWRITE: mem_we = 1'b1;
      S_EXEC:   alu_op = 2'd1;
      S_ALUWB: begin
        rf_we   = 1'b1;
        rf_wsel = 2'd1;
      end
      S_BRANCH: begin
        alu_op = 2'd3;
        pc_src = 2'd1;
        pc_we  = br_taken;
      end
      S_IEXEC: begin
        if (op_s == OP_ORI) begin
          alu_op = 2'd2;
        end else begin
          alu_op = 2'd0;
        end
      end
      S_IWB: rf_we = 1'b1;
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = 2'd2;
      end
`ifdef MC_CONTROL_JAL_EN
      S_LINK: begin
        rf_we   = 1'b1;
        rf_wsel = 2'd2;
        pc_we   = 1'b1;
        pc_src  = 2'd2;
      end
`endif
      default: begin
        pc_we = 1'b0;
      end
    endcase
  end

  // Control state, fault, wait counter and retired counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fault_q   <= FAULT_NONE;
      wait_q    <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm (MEM_TIMEOUT=4, CNT_W=4).
// The reference model works per instruction: from the opcode class and the
// chosen memory delays it lists the expected cycles and the retired count.
module tb_mc_control_fsm;

  localparam int TMO = 4;
  localparam int CW  = 4;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MADDR = 4'd3;
  localparam logic [3:0] S_MREAD = 4'd4, S_MWB = 4'd5, S_MWRITE = 4'd6, S_EXEC = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_IEXEC = 4'd10, S_IWB = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13, S_LINK = 4'd14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instr;
  logic          mem_ready;
  logic          br_taken;
  logic [3:0]    state;
  logic          pc_we, ir_we, mem_re, mem_we, rf_we;
  logic [1:0]    pc_src, alu_op, rf_wsel, fault;
  logic [CW-1:0] retired;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ret_m = 0;
  logic       trapped;
  logic [1:0] trap_f;

  mc_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .state(state), .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we),
    .rf_we(rf_we), .pc_src(pc_src), .alu_op(alu_op), .rf_wsel(rf_wsel), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1);
  end

  wire [16:0] obs = {state, pc_we, ir_we, mem_re, mem_we, rf_we, pc_src, alu_op, rf_wsel, fault};

  function automatic logic [16:0] ev(input logic [3:0] st, input logic pw, input logic iw,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic [1:0] ps, input logic [1:0] ao,
                                     input logic [1:0] ws, input logic [1:0] fl);
    return {st, pw, iw, mr, mw, rw, ps, ao, ws, fl};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    logic [CW-1:0] e;
    e = CW'(ret_m % (1 << CW));
    n_cmp++;
    assert (retired === e) else begin
      n_bad++;
      $error("FAIL %s: observed retired %0d expected %0d", tag, retired, e);
    end
  endtask

  // One clock: drive inputs, check mid-cycle, advance to just past the next edge.
  task automatic cyc(input logic rdy, input logic br, input string tag, input logic [16:0] exp);
    mem_ready = rdy;
    br_taken  = br;
    #2;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  // Memory access with d miss cycles; d >= TMO means it times out into TRAP.
  task automatic mem_phase(input logic [3:0] st, input int d, input logic is_fetch,
                           input string tag, output logic ok);
    logic re, we;
    re = (st != S_MWRITE);
    we = (st == S_MWRITE);
    if (d >= TMO) begin
      for (int k = 0; k < TMO; k++) cyc(1'b0, rb(), tag, ev(st, 1'b0, 1'b0, re, we, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      trapped = 1'b1;
      trap_f  = 2'b10;
      ok      = 1'b0;
    end else begin
      for (int k = 0; k < d; k++) cyc(1'b0, rb(), tag, ev(st, 1'b0, 1'b0, re, we, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      cyc(1'b1, rb(), tag, ev(st, is_fetch, is_fetch, re, we, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      ok = 1'b1;
    end
  endtask

  // Run one instruction from FETCH back to FETCH (or into TRAP).
  task automatic do_instr(input logic [31:0] ins, input int fd, input int md, input logic br);
    logic ok;
    logic [5:0] op, fn;
    instr = ins;
    op = ins[31:26];
    fn = ins[5:0];
    mem_phase(S_FETCH, fd, 1'b1, "fetch", ok);
    if (!ok) return;
    cyc(rb(), rb(), "decode", ev(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    if (op == 6'b100011 || op == 6'b101011) begin
      cyc(rb(), rb(), "maddr", ev(S_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
      if (op == 6'b100011) begin
        mem_phase(S_MREAD, md, 1'b0, "mread", ok);
        if (!ok) return;
        cyc(rb(), rb(), "mwb", ev(S_MWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
      end else begin
        mem_phase(S_MWRITE, md, 1'b0, "mwrite", ok);
        if (!ok) return;
      end
    end else if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                     fn == 6'b100101 || fn == 6'b101010)) begin
      cyc(rb(), rb(), "exec", ev(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0));
      cyc(rb(), rb(), "aluwb", ev(S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd0));
    end else if (op == 6'b000111 || op == 6'b000100) begin
      cyc(rb(), br, "branch", ev(S_BRANCH, br, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd3, 2'd0, 2'd0));
    end else if (op == 6'b001000 || op == 6'b001101) begin
      cyc(rb(), rb(), "iexec", ev(S_IEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                                  (op == 6'b001101) ? 2'd2 : 2'd0, 2'd0, 2'd0));
      cyc(rb(), rb(), "iwb", ev(S_IWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0));
    end else if (op == 6'b000010) begin
      cyc(rb(), rb(), "jump", ev(S_JUMP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 2'd0));
`ifdef MC_CONTROL_JAL_EN
    end else if (op == 6'b000011) begin
      cyc(rb(), rb(), "link", ev(S_LINK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 2'd0));
`endif
    end else begin
      trapped = 1'b1;
      trap_f  = 2'b01;
      return;
    end
    ret_m++;
  endtask

  task automatic trap_hold(input int n, input string tag);
    for (int k = 0; k < n; k++)
      cyc(rb(), rb(), tag, ev(S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, trap_f));
  endtask

  // Asynchronous reset from any point, then release and check the quiet IDLE cycle.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    ret_m   = 0;
    trapped = 1'b0;
    chk(tag, ev(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    chk_ret(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, rb(), "idle_after_release", ev(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [5:0]  ops[8];
    logic [5:0]  fns[5];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000111, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 7)];
    if (w[31:26] == 6'b000000) w[5:0] = fns[$urandom_range(0, 4)];
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    rst_n     = 1'b0;
    instr     = 32'd0;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    trapped   = 1'b0;
    trap_f    = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_state");

    // lw with immediate memory responses, back to FETCH with one retired.
    do_instr({6'b100011, 26'h0123456}, 0, 0, 1'b0);
    chk_ret("lw_retired");
    // sw with three miss cycles: the last permitted cycle completes, no fault.
    do_instr({6'b101011, 26'h0000040}, 0, 3, 1'b0);
    chk_ret("sw_retired");
    // beq taken then not taken.
    do_instr({6'b000100, 26'h0000010}, 0, 0, 1'b1);
    do_instr({6'b000100, 26'h0000010}, 1, 0, 1'b0);
    chk_ret("beq_retired");

    // Randomised legal instruction stream with in-budget delays.
    for (int i = 0; i < 40; i++) begin
      do_instr(rand_legal(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), rb());
      chk_ret("rand_retired");
    end

    // Illegal opcode.
    do_instr(32'hFC00_0000, 0, 0, 1'b0);
    trap_hold(3, "trap_illegal_op");
    do_reset("reset_after_illegal");

    // Illegal R-type funct.
    do_instr(32'h0000_0000, 2, 0, 1'b0);
    trap_hold(2, "trap_illegal_funct");
    do_reset("reset_after_funct");

    // jal: LINK when enabled, otherwise illegal.
    do_instr({6'b000011, 26'h0000100}, 0, 0, 1'b0);
`ifdef MC_CONTROL_JAL_EN
    chk_ret("jal_retired");
`else
    trap_hold(2, "trap_jal");
    do_reset("reset_after_jal");
`endif

    // Fetch timeout.
    do_instr({6'b001000, 26'h0000001}, TMO, 0, 1'b0);
    trap_hold(4, "trap_fetch_tmo");
    do_reset("reset_after_fetch_tmo");

    // Read timeout.
    do_instr({6'b100011, 26'h0000001}, 0, TMO, 1'b0);
    trap_hold(3, "trap_mread_tmo");
    do_reset("reset_after_mread_tmo");

    // Sixteen addi wrap the 4-bit retired counter back to zero.
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      w[31:26] = 6'b001000;
      do_instr(w, $urandom_range(0, TMO - 1), 0, 1'b0);
    end
    chk_ret("retired_wrap");

    // Reset in the middle of a read.
    instr = {6'b100011, 26'h0000200};
    cyc(1'b1, 1'b0, "fetch_pre_abort", ev(S_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    cyc(1'b0, 1'b0, "decode_pre_abort", ev(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    cyc(1'b0, 1'b0, "maddr_pre_abort", ev(S_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    mem_ready = 1'b0;
    chk("mread_pre_abort", ev(S_MREAD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0));
    do_reset("reset_mid_mread");
    do_instr({6'b000010, 26'h0000300}, 0, 0, 1'b0);
    chk_ret("jump_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles a memory state waits for mem_ready before fault; legal range 1..255.
REQ-002 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  32  current instruction-register contents; op=instr[31:26], funct=instr[5:0].
REQ-006 mem_ready  input  1  memory completes the access requested this cycle.
REQ-007 br_taken  input  1  datapath branch condition (bgtz: rs>0; beq: rs==rt), sampled in BRANCH.
REQ-008 state  output  4  current state encoding.
REQ-009 pc_we, ir_we, mem_re, mem_we, rf_we  output  1 each  write/read strobes.
REQ-010 pc_src  output  2  0 PC+4, 1 branch target, 2 jump target.
REQ-011 alu_op  output  2  0 add, 1 funct-decoded, 2 or, 3 sub-compare.
REQ-012 rf_wsel  output  2  0 rt, 1 rd, 2 $31 (link).
REQ-013 fault  output  2  00 none, 01 illegal opcode/funct, 10 memory timeout.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 States/encodings: IDLE 0, FETCH 1, DECODE 2, MADDR 3, MREAD 4, MWB 5, MWRITE 6, EXEC 7, ALUWB 8, BRANCH 9, IEXEC 10, IWB 11, JUMP 12, TRAP 13, LINK 14.
REQ-016 State register only sequential control; strobes decoded combinationally from state plus mem_ready/br_taken (Moore except noted).
REQ-017 IDLE -> FETCH unconditionally, one cycle after reset release.
REQ-018 FETCH: mem_re=1; on mem_ready: ir_we=1, pc_we=1, pc_src=0, next DECODE; else stay.
REQ-019 DECODE: lw/sw(100011/101011) -> MADDR; R-type op 000000 with funct add/sub/and/or/slt -> EXEC; bgtz 000111 or beq 000100 -> BRANCH; addi 001000 or ori 001101 -> IEXEC; j 000010 -> JUMP; anything else -> TRAP with fault=01.
REQ-020 MADDR: alu_op=0; next MREAD if lw else MWRITE.
REQ-021 MREAD: mem_re=1, waits on mem_ready, then MWB; MWB: rf_we=1, rf_wsel=0, -> FETCH.
REQ-022 MWRITE: mem_we=1 held until mem_ready, then FETCH.
REQ-023 EXEC: alu_op=1 -> ALUWB; ALUWB: rf_we=1, rf_wsel=1 -> FETCH.
REQ-024 BRANCH: alu_op=3; pc_we=br_taken, pc_src=1 -> FETCH in one cycle.
REQ-025 IEXEC: alu_op=0 (addi) or 2 (ori) -> IWB; IWB: rf_we=1, rf_wsel=0 -> FETCH.
REQ-026 JUMP: pc_we=1, pc_src=2 -> FETCH.
REQ-027 Wait counter: cleared on entry to FETCH/MREAD/MWRITE, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> TRAP, fault=10.
REQ-028 mem_ready in the same cycle the counter reaches MEM_TIMEOUT: completion wins, no fault.
REQ-029 TRAP absorbing: all strobes 0, fault held; exit only by reset.
REQ-030 retired increments by 1 on each transition into FETCH from any state other than IDLE; wraps modulo 2^CNT_W.
REQ-031 Unused state codes (15, and 14 when macro off) -> TRAP, fault=01.

Reset
REQ-032 rst_n low: state=IDLE, fault=00, retired=0, wait counter=0, all strobes 0, immediately and asynchronously.
REQ-033 Reset mid-access (any state) abandons the access; no strobe asserted in the cycle after release.

Configuration
REQ-034 Macro MC_CONTROL_JAL_EN: defined -> jal 000011 decodes to LINK: rf_we=1, rf_wsel=2, pc_we=1, pc_src=2, -> FETCH; retired counts it.
REQ-035 Without MC_CONTROL_JAL_EN: jal is illegal (TRAP, fault=01), LINK unreachable, rf_wsel never 2.

Verification
REQ-036 Reset release, instr=lw, mem_ready=1 always -> IDLE,FETCH,DECODE,MADDR,MREAD,MWB,FETCH; retired=1.
REQ-037 sw with mem_ready low 3 cycles in MWRITE -> mem_we high 4 cycles, then FETCH; fault=00.
REQ-038 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles, fault=10, strobes 0 until rst_n.
REQ-039 beq with br_taken=1 then 0 -> pc_we=1,pc_src=1 first; pc_we=0 second; both return to FETCH.
REQ-040 op 111111 -> TRAP, fault=01; jal -> LINK with rf_wsel=2 only when MC_CONTROL_JAL_EN defined, else TRAP fault=01.
REQ-041 CNT_W=4, 16 addi instructions -> retired wraps to 0; rst_n pulsed during MREAD -> state=IDLE same cycle, retired=0.
